comb_resp_checker: RTL and testbench

- Hardware response checker for a 4-input, 1-output combinational block; it is the receiving end of the exhaustive-stimulus driver.
- Samples each (DCBA code, Y) pair that the driver presents and compares Y against a parameterised 16-entry truth table.
- Tracks which codes have been seen, counts mismatches, latches the first failing code, and flags pass/fail once all 16 codes are covered.
- Sits beside the DUT in self-checking benches and on-board smoke tests.

---
 rtl/comb_resp_checker.sv | 62 ++++++
 tb/tb_comb_resp_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/comb_resp_checker.sv
// comb_resp_checker: compares sampled (DCBA code, Y) pairs against a 16-entry truth table and reports coverage and pass/fail
module comb_resp_checker #(
    parameter logic [15:0] EXPECT = 16'h6996,
    parameter int          ERR_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_code,
    input  logic             in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [3:0]       first_err_code,
    output logic [15:0]      seen_mask,
    output logic [4:0]       code_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic accept, mismatch, is_new, finish, clear;
    logic [ERR_W-1:0] err_nx;
    always_comb begin
        accept   = state == RUN && in_valid;
        mismatch = in_y != EXPECT[in_code];
        is_new   = !seen_mask[in_code];
        finish   = accept && is_new && code_cnt == 5'd15;
        clear    = start && state != RUN;
        err_nx   = (accept && mismatch && err_cnt != {ERR_W{1'b1}}) ? err_cnt + 1'b1 : err_cnt;
        state_nx = clear ? RUN : finish ? DONE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_code  <= '0;
            seen_mask       <= '0;
            code_cnt        <= '0;
        end else if (accept) begin
            err_cnt <= err_nx;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_code  <= in_code;
            end
            if (is_new) begin
                seen_mask[in_code] <= 1'b1;
                code_cnt           <= code_cnt + 5'd1;
            end
            // pass must include the compare of the sample that completes coverage
            if (finish) pass <= err_nx == '0;
        end
    end
endmodule

// File: tb/tb_comb_resp_checker.sv
// tb_comb_resp_checker: directed runs; expected run results are queued and checked when done rises
module tb_comb_resp_checker;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, in_y = 0;
    logic [3:0] in_code = 0;
    logic busy, done, pass, fev, busy3, done3, pass3, fev3;
    logic [4:0] err_cnt, code_cnt, code_cnt3;
    logic [2:0] err_cnt3;
    logic [3:0] fec, fec3;
    logic [15:0] seen_mask, seen_mask3;
    int errors = 0, checks = 0;
    logic done_d = 0;

    typedef struct packed {
        logic        pass;
        logic [4:0]  err;
        logic        fev;
        logic [3:0]  fec;
        logic [4:0]  cnt;
        logic [15:0] mask;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    comb_resp_checker dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_code(in_code), .in_y(in_y),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_valid(fev),
        .first_err_code(fec), .seen_mask(seen_mask), .code_cnt(code_cnt)
    );

    comb_resp_checker #(.ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_code(in_code), .in_y(in_y),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err_cnt3), .first_err_valid(fev3),
        .first_err_code(fec3), .seen_mask(seen_mask3), .code_cnt(code_cnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 16'h6996 is odd parity of the code
    function automatic logic good_y(input logic [3:0] k);
        return ^k;
    endfunction

    always @(negedge clk) begin
        if (done && !done_d) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("run_pass", pass, e.pass);
                chk("run_err_cnt", err_cnt, e.err);
                chk("run_first_err_valid", fev, e.fev);
                chk("run_first_err_code", fec, e.fec);
                chk("run_code_cnt", code_cnt, e.cnt);
                chk("run_seen_mask", seen_mask, e.mask);
            end
        end
        done_d = done;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_fev"}, fev, 0);
        chk({tag, "_fec"}, fec, 0);
        chk({tag, "_seen_mask"}, seen_mask, 0);
        chk({tag, "_code_cnt"}, code_cnt, 0);
    endtask

    task automatic do_start(input logic with_sample);
        @(negedge clk);
        start = 1; in_valid = with_sample; in_code = 0; in_y = !good_y(0);
        @(negedge clk);
        start = 0; in_valid = 0;
    endtask

    task automatic send(input logic [3:0] code, input logic flip);
        @(negedge clk);
        in_valid = 1; in_code = code; in_y = good_y(code) ^ flip;
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 0;

        // clean ordered run
        do_start(0);
        chk("start_busy", busy, 1);
        q.push_back('{1'b1, 5'd0, 1'b0, 4'd0, 5'd16, 16'hFFFF});
        for (int i = 0; i < 16; i++) begin
            send(i[3:0], 0);
            if (i == 15) chk("busy_before_last", busy, 1);
        end
        idle_in();
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);

        // errors at codes 5 and 9
        do_start(0);
        chk("restart_done_drops", done, 0);
        q.push_back('{1'b0, 5'd2, 1'b1, 4'd5, 5'd16, 16'hFFFF});
        for (int i = 0; i < 16; i++) send(i[3:0], i == 5 || i == 9);
        idle_in();
        chk("err2_done", done, 1);
        chk("err2_dut3_err_cnt", err_cnt3, 2);

        // duplicate code 3, wrong the second time
        do_start(0);
        q.push_back('{1'b0, 5'd1, 1'b1, 4'd3, 5'd16, 16'hFFFF});
        send(3, 0);
        send(3, 1);
        send(0, 0);
        send(1, 0);
        send(2, 0);
        for (int i = 4; i < 16; i++) send(i[3:0], 0);
        idle_in();
        chk("dup_done", done, 1);

        // missing code 15: stays in RUN, then async reset
        do_start(0);
        for (int i = 0; i < 15; i++) send(i[3:0], 0);
        idle_in();
        repeat (20) @(negedge clk);
        chk("stuck_busy", busy, 1);
        chk("stuck_done", done, 0);
        chk("stuck_code_cnt", code_cnt, 15);
        chk("stuck_seen_mask", seen_mask, 16'h7FFF);
        rst = 1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 0;
        send(15, 1);
        idle_in();
        chk("idle_ignores_valid", code_cnt, 0);
        chk("idle_ignores_err", err_cnt, 0);

        // all-inverted 40 samples
        do_start(0);
        q.push_back('{1'b0, 5'd16, 1'b1, 4'd0, 5'd16, 16'hFFFF});
        for (int i = 0; i < 40; i++) begin
            send(i[3:0], 1);
            if (i == 16) chk("inv_done_after_16", done, 1);
        end
        idle_in();
        chk("inv_err_cnt_hold", err_cnt, 16);
        chk("inv_dut3_saturate", err_cnt3, 7);
        chk("inv_dut3_pass", pass3, 0);

        // start from DONE with a sample in the same cycle
        do_start(1);
        chk("restart_busy", busy, 1);
        chk("restart_done", done, 0);
        chk("restart_err_cnt", err_cnt, 0);
        chk("restart_code_cnt", code_cnt, 0);
        chk("restart_seen_mask", seen_mask, 0);
        chk("restart_fev", fev, 0);
        q.push_back('{1'b1, 5'd0, 1'b0, 4'd0, 5'd16, 16'hFFFF});
        for (int i = 15; i >= 0; i--) send(i[3:0], 0);
        idle_in();
        chk("final_done", done, 1);
        chk("final_dut3_pass", pass3, 1);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
